// File: rtl/bpd_pkg.sv
// Shared types and defaults for the serial bit pattern detector.
package bpd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } bpd_state_t;

  localparam int DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag for an
// increment attempted at the maximum value.
module sat_counter #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (&q) begin
        sat <= 1'b1;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_pattern_detector.sv
// Serial pattern matcher: sliding window, fill/run FSM,
// registered detect pulse and saturating match counter.
module bit_pattern_detector
  import bpd_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic [1:0]       state_o
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  bpd_state_t         state;
  bpd_state_t         state_nxt;
  logic [PAT_LEN-1:0] window;
  logic [PAT_LEN-1:0] win_nxt;
  logic [FW-1:0]      fill;
  logic               full_now;
  logic               hit;

  assign win_nxt = {window[PAT_LEN-2:0], in_bit};

  // the bit being accepted counts toward a full window
  assign full_now = (fill >= LAST);
  assign hit = in_valid && !clear && full_now
             && (win_nxt == PATTERN);

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (in_valid) begin
      unique case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (fill == LAST) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      window <= '0;
      fill   <= '0;
      detect <= 1'b0;
    end else begin
      detect <= hit;
      if (in_valid) begin
        window <= win_nxt;
        if (fill != FULL) fill <= fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (hit),
    .q   (match_count),
    .sat (overflow)
  );

  assign state_o = state;

endmodule
